// File: rtl/event_source.sv
// event_source: two raw event lines -> 2-flop synchronizer -> optional debounce -> rising-edge
// detect -> event FIFO -> registered En/Slt strobes. Debounce is built when EVENT_SOURCE_DEBOUNCE_EN is defined.
module event_source #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Raw0,
    input  logic                        Raw1,
    input  logic                        Stall,
    input  logic                        Clear_Ovf,
    output logic                        En,
    output logic                        Slt,
    output logic                        Overflow,
    output logic [$clog2(FIFO_DEPTH):0] Pending
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    // Free slots this cycle: a pop frees its slot for a same-cycle push.
    function automatic logic [PW:0] free_slots(input logic [PW:0] occ, input logic pop);
        return DEPTH_C - occ + (PW + 1)'(pop);
    endfunction

    logic [1:0]          meta_r;
    logic [1:0]          sync_r;
    logic [1:0]          stable_r;
    logic [1:0]          stable_nxt_s;
    logic [1:0]          push_s;
    logic [FIFO_DEPTH-1:0] mem_r;
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [PW-1:0]       wr_idx1_s;
    logic [PW:0]         pending_r;
    logic [PW:0]         free_s;
    logic                pop_s;
    logic                acc0_s;
    logic                acc1_s;
    logic                drop_s;
    logic                en_r;
    logic                slt_r;
    logic                ovf_r;

    // Two-flop synchronizer per channel; bit 0 is channel 0.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            meta_r <= 2'b00;
            sync_r <= 2'b00;
        end else begin
            meta_r <= {Raw1, Raw0};
            sync_r <= meta_r;
        end
    end

`ifdef EVENT_SOURCE_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0][CW-1:0] cnt_r;
    logic [1:0][CW-1:0] cnt_nxt_s;

    // Debounce next state: a new level is accepted after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        cnt_nxt_s    = '0;
        stable_nxt_s = stable_r;
        for (int ch = 0; ch < 2; ch++) begin
            if (sync_r[ch] == stable_r[ch]) begin
                cnt_nxt_s[ch]    = '0;
                stable_nxt_s[ch] = stable_r[ch];
            end else if (cnt_r[ch] == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_nxt_s[ch]    = '0;
                stable_nxt_s[ch] = sync_r[ch];
            end else begin
                cnt_nxt_s[ch]    = cnt_r[ch] + CW'(1);
                stable_nxt_s[ch] = stable_r[ch];
            end
        end
    end

    // Debounce counters.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    // DEBOUNCE_CYCLES has no effect without the debounce stage.
    logic unused_db_s;
    assign unused_db_s  = (DEBOUNCE_CYCLES > 0);
    assign stable_nxt_s = sync_r;
`endif

    // Stable (conditioned) level per channel.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stable_r <= 2'b00;
        end else begin
            stable_r <= stable_nxt_s;
        end
    end

    // Only a 0->1 transition of the stable level is an event.
    assign push_s = stable_nxt_s & ~stable_r;

    // Issue and admission decisions; channel 0 is admitted first.
    always_comb begin
        pop_s     = ~Stall & (pending_r != '0);
        free_s    = free_slots(pending_r, pop_s);
        acc0_s    = push_s[0] & (free_s != '0);
        acc1_s    = push_s[1] & (free_s > (PW + 1)'(acc0_s));
        drop_s    = (push_s[0] & ~acc0_s) | (push_s[1] & ~acc1_s);
        wr_idx1_s = wr_ptr_r + PW'(acc0_s);
    end

    // Event storage and pointers; each entry holds the channel number.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mem_r     <= '0;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            pending_r <= '0;
        end else begin
            if (acc0_s) begin
                mem_r[wr_ptr_r] <= 1'b0;
            end
            if (acc1_s) begin
                mem_r[wr_idx1_s] <= 1'b1;
            end
            wr_ptr_r  <= wr_ptr_r + PW'(acc0_s) + PW'(acc1_s);
            rd_ptr_r  <= rd_ptr_r + PW'(pop_s);
            pending_r <= pending_r + (PW + 1)'(acc0_s) + (PW + 1)'(acc1_s) - (PW + 1)'(pop_s);
        end
    end

    // Registered strobe pair and sticky overflow; a drop wins over a clear.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            en_r  <= 1'b0;
            slt_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            en_r <= pop_s;
            if (pop_s) begin
                slt_r <= mem_r[rd_ptr_r];
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (Clear_Ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign En       = en_r;
    assign Slt      = slt_r;
    assign Overflow = ovf_r;
    assign Pending  = pending_r;

endmodule

// File: tb/tb_event_source.sv
// Self-checking bench for event_source: directed scenarios plus random traffic, all checked
// against a queue-based reference model built from the event rules.
module tb_event_source;
    localparam int DB    = 4;
    localparam int DEPTH = 4;
`ifdef EVENT_SOURCE_DEBOUNCE_EN
    localparam int DB_M = DB;
`else
    localparam int DB_M = 1;
`endif
    localparam int HOLD = DB_M + 3;

    logic       Clk       = 1'b0;
    logic       Reset     = 1'b0;
    logic       Raw0      = 1'b0;
    logic       Raw1      = 1'b0;
    logic       Stall     = 1'b0;
    logic       Clear_Ovf = 1'b0;
    logic       En;
    logic       Slt;
    logic       Overflow;
    logic [2:0] Pending;

    event_source #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Raw0(Raw0), .Raw1(Raw1), .Stall(Stall),
        .Clear_Ovf(Clear_Ovf), .En(En), .Slt(Slt), .Overflow(Overflow), .Pending(Pending)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: sample histories, accepted levels and an event queue.
    bit        m_en, m_slt, m_ovf;
    bit [31:0] raw_sh [2];
    bit [31:0] s_sh   [2];
    bit        m_stable [2];
    int        fifo_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_en = 1'b0; m_slt = 1'b0; m_ovf = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            raw_sh[ch] = '0; s_sh[ch] = '0; m_stable[ch] = 1'b0;
        end
        fifo_q.delete();
    endtask

    // One clock edge of the reference model, using the inputs present at that edge.
    task automatic model_step();
        bit push [2];
        bit s_now, all_diff, pop, drop;
        int free;
        if (!Reset) begin
            model_clear();
            return;
        end
        for (int ch = 0; ch < 2; ch++) begin
            s_now      = raw_sh[ch][1];
            raw_sh[ch] = {raw_sh[ch][30:0], (ch == 0) ? Raw0 : Raw1};
            s_sh[ch]   = {s_sh[ch][30:0], s_now};
            all_diff   = 1'b1;
            for (int k = 0; k < DB_M; k++) begin
                if (s_sh[ch][k] == m_stable[ch]) all_diff = 1'b0;
            end
            push[ch] = all_diff && !m_stable[ch];
            if (all_diff) m_stable[ch] = ~m_stable[ch];
        end
        pop  = !Stall && (fifo_q.size() > 0);
        free = DEPTH - fifo_q.size() + (pop ? 1 : 0);
        m_en = pop;
        if (pop) m_slt = (fifo_q.pop_front() != 0);
        drop = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            if (push[ch]) begin
                if (free > 0) begin
                    fifo_q.push_back(ch);
                    free--;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (Clear_Ovf) m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        chk("En", En, m_en);
        chk("Slt", Slt, m_slt);
        chk("Overflow", Overflow, m_ovf);
        chk("Pending", Pending, fifo_q.size());
    endtask

    // Called just after a falling edge: drive, clock, then check on the next falling edge.
    task automatic cycle(input bit r0, input bit r1, input bit st, input bit clr);
        Raw0 = r0; Raw1 = r1; Stall = st; Clear_Ovf = clr;
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit st);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, st, 1'b0);
    endtask

    task automatic pulse(input bit ch, input bit st);
        for (int i = 0; i < HOLD; i++) cycle(ch == 1'b0, ch == 1'b1, st, 1'b0);
        idle(HOLD, st);
    endtask

    task automatic assert_reset();
        Reset = 1'b0;
        #1;
        model_clear();
        chk("async_rst_en", En, 1'b0);
        chk("async_rst_pending", Pending, 0);
        check_outputs();
    endtask

    initial begin
        bit r0, r1, st, clr, got;
        int n_en, first;

        // Reset held with both raw lines high: everything stays cleared.
        Raw0 = 1'b1; Raw1 = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            chk("rst_en", En, 1'b0);
            chk("rst_ovf", Overflow, 1'b0);
            chk("rst_pending", Pending, 0);
        end
        idle(2, 1'b0);
        Reset = 1'b1;
        n_en = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_en += int'(En);
        end
        chk("quiet_en_count", n_en, 0);

        // Single event on channel 1.
        n_en = 0; first = -1;
        for (int i = 0; i < DB_M + 12; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == DB_M + 1) chk("single_pending_1", Pending, 1);
            if (En) begin
                n_en++;
                if (first < 0) first = i;
                chk("single_slt", Slt, 1'b1);
            end
        end
        chk("single_en_count", n_en, 1);
        chk("single_en_time", first, DB_M + 2);
        n_en = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_en += int'(En);
        end
        chk("fall_no_en", n_en, 0);

        // Three-cycle glitch on channel 0.
        n_en = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_en += int'(En);
        end
        chk("glitch_en_count", n_en, (DB_M <= 3) ? 1 : 0);
        chk("glitch_pending", Pending, 0);

        // Simultaneous rise on both channels.
        n_en = 0; first = -1;
        for (int i = 0; i < DB_M + 12; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            if (En) begin
                n_en++;
                if (first < 0) begin
                    first = i;
                    chk("simul_slt_first", Slt, 1'b0);
                end else begin
                    chk("simul_adjacent", i, first + 1);
                    chk("simul_slt_second", Slt, 1'b1);
                end
            end
        end
        chk("simul_en_count", n_en, 2);
        idle(HOLD + 4, 1'b0);

        // Overflow: five events into four entries while stalled.
        for (int e = 0; e < 5; e++) pulse(1'b0, 1'b1);
        chk("ovf_pending", Pending, 4);
        chk("ovf_flag", Overflow, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovf_cleared", Overflow, 1'b0);
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_en += int'(En);
        end
        chk("drain_en_count", n_en, 4);
        chk("drain_pending", Pending, 0);

        // Stall toggling with three queued events, then reset after the first issue.
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        chk("stq_pending", Pending, 3);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            st = (i % 2 == 0);
            cycle(1'b0, 1'b0, st, 1'b0);
            chk("stall_gate", En & st, 1'b0);
            if (En) begin
                got = 1'b1;
                chk("stq_first_slt", Slt, 1'b0);
                chk("stq_pending_after", Pending, 2);
            end
        end
        chk("stq_issued", got, 1'b1);
        assert_reset();
        idle(2, 1'b0);
        Reset = 1'b1;
        n_en = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_en += int'(En);
        end
        chk("post_rst_en_count", n_en, 0);
        chk("post_rst_pending", Pending, 0);

        // Random traffic checked against the model every cycle.
        r0 = 1'b0; r1 = 1'b0; st = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) r0 = ~r0;
            if ($urandom_range(7) == 0) r1 = ~r1;
            if ($urandom_range(29) == 0) st = ~st;
            clr = ($urandom_range(15) == 0);
            if ($urandom_range(999) == 0) begin
                assert_reset();
                cycle(r0, r1, st, clr);
                Reset = 1'b1;
            end
            cycle(r0, r1, st, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
